trig_window_match: RTL and testbench
====================================

// Module: trig_window_match
// PURPOSE
//  Sequential, multi-channel successor of the combinational in-range check. On a trigger it
//  computes a wrap-aware match window [start, stop] on the circular coarse-time axis and holds it.
//  While the window is open, it flags each channel hit whose timestamp lies inside the window,
//  counts matches, then closes the window on the running coarse counter and reports completion.
//  Sits between the TDC hit channels and the trigger-matching readout.
// PARAMETERS
//  WIDTH     12  coarse timestamp width; all time arithmetic is modulo 2^WIDTH
//  NCH       4   number of hit channels checked in parallel
//  CNT_W     8   match counter width (saturating)
//  CLOSE_DLY 4   coarse ticks after stop before the window closes (covers hit pipeline latency)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous, active-high reset
//  enable        in   1          0: triggers ignored, no trig_lost; an open window still completes
//  trig_valid    in   1          trigger strobe, one cycle
//  trig_time     in   WIDTH      coarse time of the trigger
//  match_offset  in   WIDTH      start = trig_time - match_offset (mod 2^WIDTH), sampled on accept
//  match_window  in   WIDTH      stop  = start + match_window (mod 2^WIDTH), sampled on accept
//  coarse_now    in   WIDTH      free-running coarse counter
//  hit_valid     in   NCH        per-channel hit strobe
//  hit_time      in   NCH*WIDTH  per-channel timestamp; channel i at [i*WIDTH +: WIDTH]
//  hit_match     out  NCH        registered per-channel in-window flag
//  win_open      out  1          state == OPEN
//  win_start     out  WIDTH      registered window start
//  win_stop      out  WIDTH      registered window stop
//  match_count   out  CNT_W      matches in current window, saturating
//  win_done      out  1          one-cycle pulse when the window closes; match_count final here
//  trig_lost     out  1          one-cycle pulse: trigger arrived while not IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including win_start, win_stop and match_count.
//  Reset mid-window: abandons the window silently; no win_done is generated.
//  FSM:
//   IDLE --trig_valid & enable--> CALC
//   CALC: 1 cycle; registers win_start/win_stop, clears match_count --> OPEN
//   OPEN: stays until coarse_now == win_stop + CLOSE_DLY (mod 2^WIDTH, equality compare) --> DONE
//   DONE: 1 cycle; win_done=1 --> IDLE
//  trig_valid & enable in CALC, OPEN or DONE: trig_lost=1 next cycle; trigger dropped.
//  In-range rule, per channel:
//   start <= stop: start <= t <= stop
//   start >  stop (wrap): t >= start | t <= stop
//   match_window=0 matches exactly t == start; match_window=2^WIDTH-1 matches every t.
//  hit_match[i] is set in cycle N+1 iff hit_valid[i] is high in cycle N, the state is OPEN in cycle N,
//   and hit_time[i] is in range. Otherwise hit_match[i]=0. Hits in CALC/DONE/IDLE never match.
//  match_count += popcount(matches in cycle N), applied in cycle N+1.
//   Saturates at 2^CNT_W-1 and holds its value until the next CALC.
//  Simultaneous matches on several channels in one cycle are all counted.
//  A hit in the last OPEN cycle is still counted and is reflected in match_count when win_done fires.
//  win_start, win_stop and match_count hold their values after DONE until the next CALC.
// TESTING
//  1 Reset: assert rst 3 cycles mid-OPEN -> all outputs 0, state IDLE, no win_done pulse.
//  2 trig_time=100, offset=10, window=20 -> win_start=90, win_stop=110;
//    hits at 89,90,110,111 -> match 0,1,1,0; win_done at coarse_now=114, match_count=2.
//  3 Wrap: trig_time=5, offset=10, window=20 -> start=4091, stop=15;
//    hits at 4090,4095,0,15,16 -> 0,1,1,1,0.
//  4 Extremes: window=0 -> only t==start matches; window=4095 -> all 4 channels match every cycle,
//    and match_count saturates at 255 and holds.
//  5 Second trigger during OPEN -> trig_lost pulses 1 cycle, window unchanged; trigger with enable=0 -> no action.
//  6 All NCH channels hit in-window in the same cycle -> hit_match=4'hF, match_count +4 next cycle.

Source files
------------

// File: rtl/trig_window_match.sv
// Trigger-matching window: on an accepted trigger computes a wrap-aware [start, stop] window on the
// circular coarse-time axis, flags in-window channel hits, counts them, and closes after stop + CLOSE_DLY.
module trig_window_match #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned NCH       = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CLOSE_DLY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 trig_valid,
    input  logic [WIDTH-1:0]     trig_time,
    input  logic [WIDTH-1:0]     match_offset,
    input  logic [WIDTH-1:0]     match_window,
    input  logic [WIDTH-1:0]     coarse_now,
    input  logic [NCH-1:0]       hit_valid,
    input  logic [NCH*WIDTH-1:0] hit_time,
    output logic [NCH-1:0]       hit_match,
    output logic                 win_open,
    output logic [WIDTH-1:0]     win_start,
    output logic [WIDTH-1:0]     win_stop,
    output logic [CNT_W-1:0]     match_count,
    output logic                 win_done,
    output logic                 trig_lost
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OPEN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_trig_time;
    logic [WIDTH-1:0] r_offset;
    logic [WIDTH-1:0] r_window;
    logic [WIDTH-1:0] r_win_start;
    logic [WIDTH-1:0] r_win_stop;
    logic [CNT_W-1:0] r_match_count;
    logic [NCH-1:0]   r_hit_match;
    logic             r_trig_lost;

    logic             w_trig_acc;
    logic [WIDTH-1:0] w_start_calc;
    logic [WIDTH-1:0] w_close_time;
    logic [NCH-1:0]   w_match;
    logic [CNT_W:0]   w_pop_cnt;
    logic [CNT_W:0]   w_sum;

    assign w_trig_acc   = trig_valid & enable;
    assign w_start_calc = r_trig_time - r_offset;
    assign w_close_time = r_win_stop + WIDTH'(CLOSE_DLY);

    // Range test wraps when start > stop: the window then covers [start, max] and [0, stop].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_match   = '0;
        w_pop_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_win_start <= r_win_stop)
                w_match[i] = (hit_time[i*WIDTH +: WIDTH] >= r_win_start) &&
                             (hit_time[i*WIDTH +: WIDTH] <= r_win_stop);
            else
                w_match[i] = (hit_time[i*WIDTH +: WIDTH] >= r_win_start) ||
                             (hit_time[i*WIDTH +: WIDTH] <= r_win_stop);
            w_match[i] = w_match[i] & hit_valid[i] & (r_state == S_OPEN);
            w_pop_cnt  = w_pop_cnt + (CNT_W+1)'(w_match[i]);
        end
        w_sum = {1'b0, r_match_count} + w_pop_cnt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trig_acc) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_OPEN;
            S_OPEN:  if (coarse_now == w_close_time) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state       <= S_IDLE;
            r_trig_time   <= '0;
            r_offset      <= '0;
            r_window      <= '0;
            r_win_start   <= '0;
            r_win_stop    <= '0;
            r_match_count <= '0;
            r_hit_match   <= '0;
            r_trig_lost   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_match <= w_match;
            r_trig_lost <= w_trig_acc & (r_state != S_IDLE);
            if (r_state == S_IDLE && w_trig_acc) begin
                r_trig_time <= trig_time;
                r_offset    <= match_offset;
                r_window    <= match_window;
            end
            if (r_state == S_CALC) begin
                r_win_start   <= w_start_calc;
                r_win_stop    <= w_start_calc + r_window;
                r_match_count <= '0;
            end else if (|w_match) begin
                r_match_count <= (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
            end
        end
    end

    assign hit_match   = r_hit_match;
    assign win_open    = (r_state == S_OPEN);
    assign win_done    = (r_state == S_DONE);
    assign win_start   = r_win_start;
    assign win_stop    = r_win_stop;
    assign match_count = r_match_count;
    assign trig_lost   = r_trig_lost;

endmodule

// File: tb/tb_trig_window_match.sv
// Directed bench for trig_window_match: normal, wrapped and extreme windows, saturation,
// lost triggers and mid-window reset, all against hand-computed values.
module tb_trig_window_match;

    localparam int WIDTH = 12;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 trig_valid;
    logic [WIDTH-1:0]     trig_time;
    logic [WIDTH-1:0]     match_offset;
    logic [WIDTH-1:0]     match_window;
    logic [WIDTH-1:0]     coarse_now;
    logic [NCH-1:0]       hit_valid;
    logic [NCH*WIDTH-1:0] hit_time;
    logic [NCH-1:0]       hit_match;
    logic                 win_open;
    logic [WIDTH-1:0]     win_start;
    logic [WIDTH-1:0]     win_stop;
    logic [CNT_W-1:0]     match_count;
    logic                 win_done;
    logic                 trig_lost;

    int n_vec = 0;
    int n_err = 0;

    trig_window_match #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W), .CLOSE_DLY(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig_valid(trig_valid),
        .trig_time(trig_time), .match_offset(match_offset), .match_window(match_window),
        .coarse_now(coarse_now), .hit_valid(hit_valid), .hit_time(hit_time),
        .hit_match(hit_match), .win_open(win_open), .win_start(win_start), .win_stop(win_stop),
        .match_count(match_count), .win_done(win_done), .trig_lost(trig_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hits(input logic [3:0] v, input int t0, input int t1, input int t2, input int t3);
        hit_valid = v;
        hit_time  = {WIDTH'(t3), WIDTH'(t2), WIDTH'(t1), WIDTH'(t0)};
    endtask

    // Trigger in IDLE, pass CALC, return with the window OPEN.
    task automatic open_window(input int tt, input int off, input int win);
        trig_valid   = 1'b1;
        enable       = 1'b1;
        trig_time    = WIDTH'(tt);
        match_offset = WIDTH'(off);
        match_window = WIDTH'(win);
        tick();
        trig_valid = 1'b0;
        tick();
        check("open", win_open, 1);
    endtask

    task automatic close_window(input int t_close);
        coarse_now = WIDTH'(t_close);
        tick();
        check("done_pulse", win_done, 1);
        coarse_now = '0;
        tick();
        check("done_one_cycle", win_done, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; trig_valid = 1'b0; trig_time = '0; match_offset = '0;
        match_window = '0; coarse_now = '0; hit_valid = '0; hit_time = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_open", win_open, 0);
        check("rst_start", win_start, 0);
        check("rst_stop", win_stop, 0);
        check("rst_count", match_count, 0);
        check("rst_hit", hit_match, 0);
        check("rst_done", win_done, 0);
        check("rst_lost", trig_lost, 0);

        // Basic window: start 90, stop 110, closes at 114.
        coarse_now = 12'd100;
        open_window(100, 10, 20);
        check("b_start", win_start, 90);
        check("b_stop", win_stop, 110);
        check("b_count0", match_count, 0);
        set_hits(4'hF, 89, 90, 110, 111);
        tick();
        check("b_hit", hit_match, 4'b0110);
        check("b_count", match_count, 2);
        set_hits(4'h0, 0, 0, 0, 0);
        coarse_now = 12'd113;
        tick();
        check("b_hit_clr", hit_match, 0);
        check("b_not_closed", win_open, 1);
        close_window(114);
        check("b_final_count", match_count, 2);
        check("b_hold_start", win_start, 90);
        check("b_lost", trig_lost, 0);

        // Wrapped window: start 4091, stop 15, closes at 19.
        coarse_now = 12'd500;
        open_window(5, 10, 20);
        check("w_start", win_start, 4091);
        check("w_stop", win_stop, 15);
        set_hits(4'hF, 4090, 4095, 0, 15);
        tick();
        check("w_hit", hit_match, 4'b1110);
        check("w_count", match_count, 3);
        set_hits(4'h1, 16, 0, 0, 0);
        tick();
        check("w_hit16", hit_match, 0);
        // Hit in the last OPEN cycle must reach match_count when win_done fires.
        set_hits(4'h1, 4091, 0, 0, 0);
        coarse_now = 12'd19;
        tick();
        check("w_done", win_done, 1);
        check("w_last_hit", hit_match, 4'b0001);
        check("w_last_count", match_count, 4);
        set_hits(4'h1, 0, 0, 0, 0);
        tick();
        check("w_done_hit_ignored", hit_match, 0);
        check("w_count_hold", match_count, 4);
        set_hits(4'h0, 0, 0, 0, 0);

        // Zero-length window: only t == start (200).
        coarse_now = 12'd0;
        open_window(200, 0, 0);
        set_hits(4'hF, 199, 200, 201, 200);
        tick();
        check("z_hit", hit_match, 4'b1010);
        check("z_count", match_count, 2);
        set_hits(4'h0, 0, 0, 0, 0);
        close_window(204);

        // Full-circle window: every hit matches, counter saturates at 255.
        coarse_now = 12'd1000;
        open_window(50, 50, 4095);
        check("f_start", win_start, 0);
        check("f_stop", win_stop, 4095);
        for (int k = 0; k < 64; k++) begin
            set_hits(4'hF, k * 64, 4095 - k, k, 2048 + k);
            tick();
            if (k == 0) check("f_all_ch", hit_match, 4'hF);
            if (k == 62) check("f_count_252", match_count, 252);
        end
        check("f_sat", match_count, 255);
        tick(); tick(); tick();
        check("f_sat_hold", match_count, 255);
        set_hits(4'h0, 0, 0, 0, 0);
        close_window(3);
        check("f_final", match_count, 255);

        // Lost trigger during OPEN; disabled trigger ignored; open window completes with enable=0.
        open_window(300, 0, 10);
        set_hits(4'hF, 300, 305, 310, 301);
        tick();
        check("l_all_ch", hit_match, 4'hF);
        check("l_count4", match_count, 4);
        set_hits(4'h0, 0, 0, 0, 0);
        trig_valid = 1'b1; trig_time = 12'd999; match_offset = 12'd1; match_window = 12'd1;
        tick();
        check("l_lost", trig_lost, 1);
        trig_valid = 1'b0;
        tick();
        check("l_lost_pulse", trig_lost, 0);
        check("l_start_kept", win_start, 300);
        check("l_stop_kept", win_stop, 310);
        enable = 1'b0; trig_valid = 1'b1;
        tick();
        check("l_dis_no_lost", trig_lost, 0);
        trig_valid = 1'b0;
        close_window(314);
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        tick();
        check("l_dis_idle", win_open, 0);
        check("l_dis_start", win_start, 300);
        check("l_dis_lost", trig_lost, 0);

        // Reset mid-window: silent abandonment.
        coarse_now = 12'd0;
        open_window(400, 0, 10);
        set_hits(4'h1, 405, 0, 0, 0);
        tick();
        check("r_count1", match_count, 1);
        set_hits(4'h0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("r_no_done", win_done, 0);
        end
        rst = 1'b0;
        coarse_now = 12'd414;
        tick();
        check("r_no_done_after", win_done, 0);
        check("r_open", win_open, 0);
        check("r_start", win_start, 0);
        check("r_stop", win_stop, 0);
        check("r_count", match_count, 0);
        check("r_hit", hit_match, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
